pwm_multi: RTL
==============

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of PWM channels (1..16).
REQ-002 SHALL have parameter CW, default 8, meaning counter, period and duty width in bits.
REQ-003 SHALL have parameter PW, default 16, meaning prescaler width in bits.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port en  input  1  global run enable.
REQ-007 SHALL have port presc  input  PW  count tick every presc+1 clk.
REQ-008 SHALL have port period  input  CW  counter terminal value; PWM cycle = period+1 ticks.
REQ-009 SHALL have port wr_en  input  1  duty write strobe, single clk.
REQ-010 SHALL have port wr_ch  input  max(1,clog2(CH))  channel index for write.
REQ-011 SHALL have port wr_duty  input  CW  duty value in ticks.
REQ-012 SHALL have port pol  input  CH  per-channel output invert.
REQ-013 SHALL have port pwm_out  output  CH  registered PWM outputs.
REQ-014 SHALL have port cycle_start  output  1  one-clk pulse at each cycle boundary.

Function
REQ-015 SHALL be single-clock; the prescaler SHALL produce a clock-enable tick, never a derived clock.
REQ-016 SHALL, with en=1, increment prescaler pcnt each clk; at pcnt==presc assert tick and clear pcnt; presc=0 gives a tick every clk.
REQ-017 SHALL, on tick, set cnt to 0 if cnt>=period_act, else cnt+1; the >= covers period reduced below cnt.
REQ-018 SHALL, on a wrap tick (cnt returns to 0), load period_act from period and duty_act[i] from duty_pend[i] for all channels.
REQ-019 SHALL, on wr_en with wr_ch<CH, write wr_duty to duty_pend[wr_ch]; wr_ch>=CH SHALL be ignored.
REQ-020 SHALL, when a write and a wrap load coincide, load the old duty_pend into duty_act and hold the new value for the next boundary.
REQ-021 SHALL drive pwm_out[i] = (cnt<duty_act[i]) XOR pol[i], registered: one clk after the cnt update.
REQ-022 SHALL give duty_act=0 a constant inactive level and duty_act>period_act a constant active level, with no glitch.
REQ-023 SHALL assert cycle_start for exactly one clk, aligned with the first pwm_out of each new cycle.
REQ-024 SHALL, with en=0, clear pcnt and cnt, drive pwm_out=pol and cycle_start=0, and copy duty_pend/period into active registers every clk.
REQ-025 SHALL, on en rising, start at cnt=0 with first cycle_start one clk later.

Reset
REQ-026 SHALL, with rst_n=0, immediately clear pcnt, cnt, duty_pend, duty_act, period_act, pwm_out and cycle_start to 0, regardless of clk.
REQ-027 SHALL, on reset release mid-operation, restart from cnt=0; no state survives reset.

Configuration
REQ-028 SHALL, with macro PWM_CENTER_ALIGN_EN defined, add port center (input, 1); center=1 counts up 0..period_act then down to 1, cycle = 2*period_act ticks, boundary at upward restart from 0.
REQ-029 SHALL, without PWM_CENTER_ALIGN_EN, omit port center and be edge-aligned only, with identical behaviour to center=0.

Verification
REQ-030 SHALL check CH=4, CW=8, presc=0, period=9, duty0=3, en=1 -> pwm_out[0] high 3 clk, low 7 clk, cycle_start every 10 clk.
REQ-031 SHALL check duty1=0 -> pwm_out[1] constant 0; duty1=10 with period=9 -> constant 1.
REQ-032 SHALL check duty2 changed from 5 to 7 at cnt=3 -> current cycle high 5 ticks, next cycle high 7 ticks.
REQ-033 SHALL check presc=2, period=9, duty0=3 -> high 9 clk, cycle 30 clk.
REQ-034 SHALL check pol[3]=1 and en=0 -> pwm_out[3]=1; rst_n low mid-cycle -> all pwm_out 0 before the next clk edge.
REQ-035 SHALL check, with PWM_CENTER_ALIGN_EN and center=1, period=4, duty0=2 -> 3 ticks high, 5 ticks low per 8-tick cycle.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler/counter, per-channel duty with boundary reload.
// Optional macro PWM_CENTER_ALIGN_EN adds a `center` input for up/down (center-aligned) counting.
module pwm_multi #(
    parameter int unsigned CH = 4,
    parameter int unsigned CW = 8,
    parameter int unsigned PW = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [PW-1:0]                        presc,
    input  logic [CW-1:0]                        period,
    input  logic                                 wr_en,
    input  logic [$clog2(CH > 1 ? CH : 2)-1:0]   wr_ch,
    input  logic [CW-1:0]                        wr_duty,
    input  logic [CH-1:0]                        pol,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                                 center,
`endif
    output logic [CH-1:0]                        pwm_out,
    output logic                                 cycle_start
);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;      // 0: counting up, 1: counting down
    logic [CW-1:0] period_act_q;
    logic [CW-1:0] duty_pend_q [CH];
    logic [CW-1:0] duty_act_q  [CH];
    logic [CH-1:0] pwm_out_q;
    logic          start_q;           // cnt has just (re)started at 0
    logic          cycle_start_q;
    logic          center_mode;
    logic          tick;
    logic          wrap;
    logic          load;

`ifdef PWM_CENTER_ALIGN_EN
    assign center_mode = center;
`else
    assign center_mode = 1'b0;
`endif

    always_comb begin
        tick   = en && (pcnt_q == presc);
        pcnt_d = (!en || tick) ? '0 : pcnt_q + PW'(1);
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        wrap   = 1'b0;
        if (!en) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (tick) begin
            if (!dir_q) begin
                // >= also catches a period lowered below the running count
                if (cnt_q >= period_act_q) begin
                    if (center_mode && cnt_q > CW'(1)) begin
                        dir_d = 1'b1;
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        wrap  = 1'b1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (cnt_q <= CW'(1)) begin
                wrap  = 1'b1;
                cnt_d = '0;
                dir_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
        load = !en || wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q        <= '0;
            cnt_q         <= '0;
            dir_q         <= 1'b0;
            period_act_q  <= '0;
            pwm_out_q     <= '0;
            start_q       <= 1'b1;
            cycle_start_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                duty_pend_q[i] <= '0;
                duty_act_q[i]  <= '0;
            end
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            // Active registers take the pre-write pending value on a coincident write
            if (load) begin
                period_act_q <= period;
                duty_act_q   <= duty_pend_q;
            end
            if (wr_en && (32'(wr_ch) < CH)) begin
                duty_pend_q[wr_ch] <= wr_duty;
            end
            start_q       <= load;
            cycle_start_q <= en && start_q;
            for (int i = 0; i < CH; i++) begin
                pwm_out_q[i] <= en ? ((cnt_q < duty_act_q[i]) ^ pol[i]) : pol[i];
            end
        end
    end

    assign pwm_out     = pwm_out_q;
    assign cycle_start = cycle_start_q;

endmodule
